// File: rtl/iob_uart_core.sv
// 8N1 UART core: independent transmit and receive engines sharing one clock,
// with a programmable bit period and a valid/ready style read port for RX data.
module iob_uart_core (
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        arst_i,
    input  logic        softreset_i,
    input  logic [15:0] div_i,
    input  logic [7:0]  txdata_wdata_i,
    input  logic        txdata_wen_i,
    output logic        txdata_ready_o,
    input  logic        txen_i,
    input  logic        rxen_i,
    output logic        txready_o,
    output logic        rxready_o,
    output logic [7:0]  rxdata_rdata_o,
    input  logic        rxdata_ren_i,
    output logic        rxdata_rvalid_o,
    input  logic        rxdata_rready_i,
    output logic        rxdata_ready_o,
    output logic        txd_o,
    input  logic        rxd_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [15:0] bit_period(input logic [15:0] div);
        bit_period = (div == 16'd0) ? 16'd1 : div;
    endfunction

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_per_q, tx_per_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_last_cnt_s;
    logic        tx_busy_s;

    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_per_q, rx_per_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rx_sync1_q, rx_sync1_d;
    logic        rx_sync2_q, rx_sync2_d;
    logic        rx_last_q, rx_last_d;
    logic        rxready_q, rxready_d;
    logic        rvalid_q, rvalid_d;
    logic        rx_done_s;
    logic        rx_last_cnt_s;
    logic [15:0] rx_half_s;

    assign tx_last_cnt_s = (tx_cnt_q == (tx_per_q - 16'd1));
    assign tx_busy_s     = (tx_state_q != ST_IDLE);
    assign rx_last_cnt_s = (rx_cnt_q == (rx_per_q - 16'd1));
    assign rx_half_s     = {1'b0, rx_per_q[15:1]};

    assign txready_o       = txen_i & ~tx_busy_s & ~softreset_i & ~arst_i;
    assign txdata_ready_o  = 1'b1;
    assign rxdata_ready_o  = 1'b1;
    assign txd_o           = txd_q;
    assign rxready_o       = rxready_q;
    assign rxdata_rdata_o  = rdata_q;
    assign rxdata_rvalid_o = rvalid_q;

    // Transmit engine next-state: a write is only accepted in IDLE while enabled.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_per_d   = tx_per_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        if (softreset_i) begin
            tx_state_d = ST_IDLE;
            tx_cnt_d   = 16'd0;
            tx_per_d   = 16'd1;
            tx_bit_d   = 3'd0;
            tx_shift_d = 8'd0;
            txd_d      = 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    txd_d = 1'b1;
                    if (txdata_wen_i && txen_i) begin
                        tx_state_d = ST_START;
                        tx_shift_d = txdata_wdata_i;
                        tx_per_d   = bit_period(div_i);
                        tx_cnt_d   = 16'd0;
                        tx_bit_d   = 3'd0;
                        txd_d      = 1'b0;
                    end else begin
                        tx_cnt_d = 16'd0;
                    end
                end
                ST_START: begin
                    if (tx_last_cnt_s) begin
                        tx_state_d = ST_DATA;
                        tx_cnt_d   = 16'd0;
                        txd_d      = tx_shift_q[0];
                    end else begin
                        tx_cnt_d = tx_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_last_cnt_s) begin
                        tx_cnt_d = 16'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = ST_STOP;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            txd_d      = tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_last_cnt_s) begin
                        tx_state_d = ST_IDLE;
                        tx_cnt_d   = 16'd0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_state_d = ST_IDLE;
                    txd_d      = 1'b1;
                end
            endcase
        end
    end

    // Receive engine next-state; START is entered with the edge cycle already counted.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_per_d   = rx_per_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_sync1_d = rxd_i;
        rx_sync2_d = rx_sync1_q;
        rx_last_d  = rx_sync2_q;
        rx_done_s  = 1'b0;
        if (softreset_i) begin
            rx_state_d = ST_IDLE;
            rx_cnt_d   = 16'd0;
            rx_per_d   = 16'd1;
            rx_bit_d   = 3'd0;
            rx_shift_d = 8'd0;
            rx_sync1_d = 1'b1;
            rx_sync2_d = 1'b1;
            rx_last_d  = 1'b1;
        end else begin
            case (rx_state_q)
                ST_IDLE: begin
                    if (rxen_i && rx_last_q && !rx_sync2_q) begin
                        rx_state_d = ST_START;
                        rx_per_d   = bit_period(div_i);
                        rx_cnt_d   = 16'd1;
                        rx_bit_d   = 3'd0;
                    end else begin
                        rx_cnt_d = 16'd0;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q >= rx_half_s) begin
                        rx_cnt_d = 16'd0;
                        if (rx_sync2_q) begin
                            rx_state_d = ST_IDLE;
                        end else begin
                            rx_state_d = ST_DATA;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_last_cnt_s) begin
                        rx_cnt_d   = 16'd0;
                        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_last_cnt_s) begin
                        rx_state_d = ST_IDLE;
                        rx_cnt_d   = 16'd0;
                        rx_done_s  = rx_sync2_q;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    rx_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Read port: presented data is frozen from the read strobe until the handshake ends.
    always_comb begin
        rx_byte_d = rx_byte_q;
        rxready_d = rxready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (softreset_i) begin
            rx_byte_d = 8'd0;
            rxready_d = 1'b0;
            rvalid_d  = 1'b0;
            rdata_d   = 8'd0;
        end else begin
            if (rx_done_s) begin
                rx_byte_d = rx_shift_q;
                rxready_d = 1'b1;
            end else if (rxdata_ren_i) begin
                rxready_d = 1'b0;
            end else begin
                rxready_d = rxready_q;
            end
            if (rxdata_ren_i) begin
                rvalid_d = 1'b1;
            end else if (rvalid_q && rxdata_rready_i) begin
                rvalid_d = 1'b0;
            end else begin
                rvalid_d = rvalid_q;
            end
            if (rvalid_q || rxdata_ren_i) begin
                rdata_d = rdata_q;
            end else if (rx_done_s) begin
                rdata_d = rx_shift_q;
            end else begin
                rdata_d = rx_byte_q;
            end
        end
    end

    // State registers for both engines, frozen while the clock enable is low.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_per_q   <= 16'd1;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_per_q   <= 16'd1;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_byte_q  <= 8'd0;
            rdata_q    <= 8'd0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_last_q  <= 1'b1;
            rxready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
        end else if (cke_i) begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_per_q   <= tx_per_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_per_q   <= rx_per_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rdata_q    <= rdata_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_last_q  <= rx_last_d;
            rxready_q  <= rxready_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: doc/iob_uart_core.md
IOB_UART_CORE -- requirements
Module: iob_uart_core

Interface
REQ-001 Parameters: none; the frame format is fixed at 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
REQ-002 clk_i  in  1  system clock; the single clock domain.
REQ-003 cke_i  in  1  clock enable; all state holds when low.
REQ-004 arst_i  in  1  reset, asynchronous, active-high.
REQ-005 softreset_i  in  1  synchronous soft reset of both engines.
REQ-006 div_i  in  16  bit period in clk_i cycles.
REQ-007 txdata_wdata_i  in  8  byte to transmit.
REQ-008 txdata_wen_i  in  1  one-cycle write strobe for txdata_wdata_i.
REQ-009 txdata_ready_o  out  1  write-accept indication; constant 1.
REQ-010 txen_i  in  1  transmitter enable.
REQ-011 rxen_i  in  1  receiver enable.
REQ-012 txready_o  out  1  transmitter can accept a byte.
REQ-013 rxready_o  out  1  received byte is pending.
REQ-014 rxdata_rdata_o  out  8  received byte.
REQ-015 rxdata_ren_i  in  1  read request strobe.
REQ-016 rxdata_rvalid_o  out  1  read data valid.
REQ-017 rxdata_rready_i  in  1  read data accepted.
REQ-018 rxdata_ready_o  out  1  read-accept indication; constant 1.
REQ-019 txd_o  out  1  serial output; idles high.
REQ-020 rxd_i  in  1  serial input; asynchronous to clk_i.

Function
REQ-021 Bit period P SHALL be max(div_i, 1) cycles; div_i SHALL be sampled at the start of each TX or RX frame and held for that whole frame.
REQ-022 txready_o SHALL equal txen_i & ~tx_busy & ~softreset_i.
REQ-023 A txdata_wen_i pulse while txready_o=1 SHALL latch the byte, set tx_busy the next cycle, and start the frame that same next cycle.
REQ-024 A txdata_wen_i pulse while txready_o=0 SHALL be ignored and SHALL NOT corrupt a frame in progress.
REQ-025 TX FSM states: IDLE, START, DATA (bit counter 0..7), STOP; each state lasts P cycles.
REQ-026 Frame timing: txd_o=0 for P cycles, then bits d0..d7, then 1 for P cycles; total 10*P cycles.
REQ-027 tx_busy SHALL clear at the end of STOP, so txready_o rises exactly 10*P cycles after the first start-bit cycle.
REQ-028 Deasserting txen_i mid-frame SHALL NOT abort the frame; it only blocks new writes.
REQ-029 rxd_i SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-030 RX FSM states: IDLE, START, DATA, STOP.
REQ-031 RX start: while in IDLE with rxen_i=1, a 1-to-0 transition enters START.
REQ-032 RX start check: the line is sampled after floor(P/2) cycles; if it reads 1, return to IDLE (glitch rejected).
REQ-033 RX data bits SHALL be sampled every P cycles after the start-bit midpoint into d0..d7.
REQ-034 RX stop bit: sampled P cycles after d7; if 1, load rxdata_rdata_o and set rxready_o; if 0 (framing error), discard the byte and leave rxready_o unchanged.
REQ-035 RX SHALL return to IDLE immediately after the stop sample, so back-to-back frames are received.
REQ-036 Overrun: a new valid byte overwrites rxdata_rdata_o and rxready_o stays 1.
REQ-037 Deasserting rxen_i mid-frame SHALL NOT abort the frame; it only blocks new start detection.
REQ-038 Read handshake: an rxdata_ren_i pulse sets rxdata_rvalid_o the next cycle.
REQ-039 rxdata_rvalid_o and rxdata_rdata_o SHALL be held stable until the cycle rxdata_rready_i=1; rxdata_rvalid_o clears the following cycle.
REQ-040 rxdata_ren_i SHALL clear rxready_o the next cycle.
REQ-041 If a byte completes in the same cycle as rxdata_ren_i, rxready_o SHALL stay 1 and the new byte SHALL be presented only after rxdata_rvalid_o clears.
REQ-042 A read with rxready_o=0 SHALL return the last received byte with normal handshake timing.

Reset
REQ-043 When arst_i=1, outputs SHALL take these values: txd_o=1, txready_o=0, rxready_o=0, rxdata_rdata_o=0, rxdata_rvalid_o=0, both FSMs IDLE, synchronizer flops=1.
REQ-044 softreset_i=1 SHALL apply the REQ-043 state synchronously on the next enabled clock, aborting any frame in progress; txd_o returns to 1 immediately that cycle.
REQ-045 txdata_ready_o and rxdata_ready_o SHALL be 1 in all states, including reset.

Verification
REQ-046 Scenario: div=4, txen=1, write 0xA5 -> txd_o pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; txready_o low for exactly 40 cycles.
REQ-047 Scenario: div=8, rxen=1, drive frame 0x3C on rxd_i -> rxready_o=1 and rxdata_rdata_o=0x3C; ren pulse -> rvalid_o=1 next cycle, held while rready=0; rready=1 -> rvalid_o=0 and rxready_o=0.
REQ-048 Scenario: rxd_i low for 2 cycles with div=8 -> no byte received; 0x55 frame with stop bit 0 -> rxready_o stays 0.
REQ-049 Scenario: two frames 0x11 then 0x22 with no read between -> rxdata_rdata_o=0x22, rxready_o=1.
REQ-050 Scenario: softreset_i pulse mid-TX frame -> txd_o=1 the next cycle; txready_o=1 the cycle after softreset_i falls; a new write transmits correctly.
REQ-051 Scenario: write during a busy frame, and div_i changed mid-frame -> the in-flight frame is unaffected and the second byte is dropped.
